// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared fetch-unit state encoding and parameter defaults
package cpu_fetch_pkg;

    localparam int DEF_PC_W     = 16;
    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_RESET_PC = 10;

    typedef enum logic [2:0] {
        START = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } fetchState_e;

endpackage

// File: rtl/cpu_fetch_unit_pc_adder.sv
// pc_adder: modulo-2^PC_W program-counter incrementer by PC_STEP
module pc_adder #(
    parameter int PC_W    = 16,
    parameter int PC_STEP = 1
) (
    input  logic [PC_W-1:0] a,
    output logic [PC_W-1:0] sum
);

    assign sum = a + PC_W'(PC_STEP);

endmodule

// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: multi-cycle fetch sequencer with memory req/ack, decode valid/ready, redirect flush and halt
module cpu_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int RESET_PC = DEF_RESET_PC,
    parameter int PC_STEP  = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_cnt
);

    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    fetchState_e     state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] fetchAddr;
    logic [PC_W-1:0] nextPc;

    pc_adder #(.PC_W(PC_W), .PC_STEP(PC_STEP)) pcAdder (.a(fetchAddr), .sum(nextPc));

    // Handshake outputs decode straight from state so redirect/ready never reach imem_req/imem_addr combinationally
    assign imem_req    = (state == REQ) || (state == FLUSH);
    assign imem_addr   = fetchAddr;
    assign instr_valid = state == HOLD;
    assign halted      = state == HALT;

    // Fetch FSM: redirect wins over ack, handoff and halt; FLUSH waits out the stale request at its original address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= START;
            pc        <= RST_PC;
            fetchAddr <= RST_PC;
            instr     <= '0;
            instr_pc  <= '0;
            fetch_cnt <= '0;
        end else begin
            if (redirect)
                pc <= redirect_pc;
            else if (state == REQ && imem_ack)
                pc <= nextPc;
            if (state == HOLD && instr_ready)
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            case (state)
                START: begin
                    fetchAddr <= redirect ? redirect_pc : pc;
                    state     <= REQ;
                end
                REQ: begin
                    if (redirect) begin
                        if (imem_ack)
                            fetchAddr <= redirect_pc;
                        else
                            state <= FLUSH;
                    end else if (imem_ack) begin
                        instr    <= imem_rdata;
                        instr_pc <= fetchAddr;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        fetchAddr <= redirect_pc;
                        state     <= REQ;
                    end else if (instr_ready) begin
                        if (halt) begin
                            state <= HALT;
                        end else begin
                            fetchAddr <= pc;
                            state     <= REQ;
                        end
                    end
                end
                FLUSH: begin
                    if (imem_ack) begin
                        fetchAddr <= redirect ? redirect_pc : pc;
                        state     <= REQ;
                    end
                end
                HALT: begin
                    if (redirect) begin
                        fetchAddr <= redirect_pc;
                        state     <= REQ;
                    end
                end
                default: state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// tb_cpu_fetch_unit: directed scoreboard bench for the fetch sequencer, plus an 8-bit wrap instance
module tb_cpu_fetch_unit;

    logic        clk = 0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic [15:0] fetch_cnt;

    logic        rst8n;
    logic        req8;
    logic [7:0]  addr8;
    logic        ack8;
    logic [7:0]  instr8;
    logic [7:0]  instrPc8;
    logic        valid8;
    logic        halted8;
    logic [7:0]  cnt8;

    int errors = 0;
    int checks = 0;
    int waitCnt = 0;
    int waitStates = 0;
    logic [31:0] reqQ[$];
    logic [31:0] hopQ[$];
    logic [31:0] q8[$];

    cpu_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .halted(halted), .fetch_cnt(fetch_cnt)
    );

    cpu_fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC('hFE), .PC_STEP(1), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst8n), .imem_req(req8), .imem_addr(addr8),
        .imem_ack(ack8), .imem_rdata(addr8), .instr(instr8), .instr_pc(instrPc8),
        .instr_valid(valid8), .instr_ready(1'b1), .redirect(1'b0),
        .redirect_pc(8'h00), .halt(1'b0), .halted(halted8), .fetch_cnt(cnt8)
    );

    always #5 clk = ~clk;

    // Memory model: returns the address as data after waitStates wait cycles
    assign imem_ack   = imem_req && (waitCnt >= waitStates);
    assign imem_rdata = imem_addr;
    assign ack8       = req8;

    // Wait-state counter of the memory model
    always @(posedge clk) waitCnt <= (imem_req && !imem_ack) ? waitCnt + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted memory response and every decode handoff is popped and compared
    always @(negedge clk) begin
        logic [31:0] e;
        if (imem_req && imem_ack) begin
            e = reqQ.size() > 0 ? reqQ.pop_front() : 32'hxxxxxxxx;
            chk("ackAddr", {16'h0, imem_addr}, e);
        end
        if (instr_valid && instr_ready) begin
            e = hopQ.size() > 0 ? hopQ.pop_front() : 32'hxxxxxxxx;
            chk("handoffPc", {16'h0, instr_pc}, e);
            chk("handoffInstr", {16'h0, instr}, e);
        end
        if (req8 && ack8 && q8.size() > 0)
            chk("wrapAddr", {24'h0, addr8}, q8.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; rst8n = 0; instr_ready = 1; redirect = 0; redirect_pc = 0; halt = 0;
        reqQ = '{10, 11, 12, 13};
        hopQ = '{10, 11, 12, 13};
        repeat (2) step();
        chk("rstReq", imem_req, 0);
        chk("rstAddr", imem_addr, 10);
        chk("rstValid", instr_valid, 0);
        chk("rstInstr", instr, 0);
        chk("rstInstrPc", instr_pc, 0);
        chk("rstHalted", halted, 0);
        chk("rstCnt", fetch_cnt, 0);
        rst_n = 1;
        chk("startNoReq", imem_req, 0);
        step();
        chk("firstReq", imem_req, 1);
        chk("firstAddr", imem_addr, 10);
        for (int i = 0; i < 40 && fetch_cnt != 3; i++) step();
        chk("cnt3", fetch_cnt, 3);
        instr_ready = 0;
        repeat (4) begin
            step();
            chk("stallValid", instr_valid, 1);
            chk("stallPc", instr_pc, 13);
            chk("stallInstr", instr, 13);
            chk("stallNoReq", imem_req, 0);
            chk("stallCnt", fetch_cnt, 3);
        end
        halt = 1; instr_ready = 1;
        step();
        halt = 0;
        chk("haltHalted", halted, 1);
        chk("haltNoValid", instr_valid, 0);
        chk("haltCnt", fetch_cnt, 4);
        repeat (3) begin
            step();
            chk("haltStays", halted, 1);
            chk("haltNoReq", imem_req, 0);
        end
        redirect = 1; redirect_pc = 16'h0100; waitStates = 3;
        reqQ.push_back(32'h100); reqQ.push_back(32'h101); reqQ.push_back(32'h40);
        hopQ.push_back(32'h100); hopQ.push_back(32'h40);
        step();
        redirect = 0;
        chk("resumeHalted", halted, 0);
        chk("resumeReq", imem_req, 1);
        chk("resumeAddr", imem_addr, 16'h0100);
        for (int i = 0; i < 40 && !(imem_req && imem_addr == 16'h0101 && waitCnt == 1); i++) step();
        chk("secondWait", waitCnt, 1);
        redirect = 1; redirect_pc = 16'h0040;
        step();
        redirect = 0;
        chk("flushReq", imem_req, 1);
        chk("flushAddr", imem_addr, 16'h0101);
        chk("flushNoValid", instr_valid, 0);
        for (int i = 0; i < 40 && fetch_cnt != 6; i++) step();
        chk("cnt6", fetch_cnt, 6);
        waitStates = 0; instr_ready = 0;
        reqQ.push_back(32'h41); hopQ.push_back(32'h41);
        for (int i = 0; i < 10 && !instr_valid; i++) step();
        chk("holdBeforeCombo", instr_pc, 16'h0041);
        instr_ready = 1; halt = 1; redirect = 1; redirect_pc = 16'h0200; waitStates = 5;
        reqQ.push_back(32'h200); hopQ.push_back(32'h200);
        step();
        redirect = 0; halt = 0;
        chk("comboNotHalted", halted, 0);
        chk("comboReq", imem_req, 1);
        chk("comboAddr", imem_addr, 16'h0200);
        chk("comboCnt", fetch_cnt, 7);
        for (int i = 0; i < 40 && fetch_cnt != 8; i++) step();
        chk("cnt8", fetch_cnt, 8);
        step();
        chk("midReq", imem_req, 1);
        chk("midAddr", imem_addr, 16'h0201);
        #2 rst_n = 0;
        #1;
        chk("asyncReq", imem_req, 0);
        chk("asyncAddr", imem_addr, 10);
        chk("asyncValid", instr_valid, 0);
        chk("asyncInstr", instr, 0);
        chk("asyncInstrPc", instr_pc, 0);
        chk("asyncCnt", fetch_cnt, 0);
        chk("asyncHalted", halted, 0);
        waitStates = 0; halt = 1;
        reqQ.push_back(10); hopQ.push_back(10);
        step();
        step();
        rst_n = 1;
        for (int i = 0; i < 20 && !halted; i++) step();
        chk("restartHalted", halted, 1);
        chk("restartCnt", fetch_cnt, 1);
        chk("restartPc", instr_pc, 10);
        chk("reqQEmpty", reqQ.size(), 0);
        chk("hopQEmpty", hopQ.size(), 0);
        q8 = '{32'hFE, 32'hFF, 32'h00};
        rst8n = 1;
        for (int i = 0; i < 20 && q8.size() > 0; i++) step();
        chk("wrapDone", q8.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
